// File: rtl/ram8_fifo_ctrl.sv
// Sequencing front-end that turns an 8x16 RAM8 into a 9-entry FWFT FIFO.
// The RAM holds the tail of the queue; a registered output slot holds the head.
module ram8_fifo_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  level,
  output logic [2:0]  ram_address,
  output logic        ram_write,
  output logic [15:0] ram_in,
  input  logic [15:0] ram_out
);

  // Handshakes: a word moves on a side only in a cycle where valid and ready
  // are both high at the rising edge; valid never waits on ready.

  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  ram_count;
  logic        out_valid_q;
  logic [15:0] out_data_q;

  logic pop;
  logic slot_free;
  logic ram_empty;
  logic fetch;
  logic bypass;
  logic accept;

  assign pop       = out_valid_q & out_ready;
  assign slot_free = !out_valid_q | pop;
  assign ram_empty = (ram_count == 4'd0);
  assign fetch     = slot_free & !ram_empty;
  assign bypass    = slot_free & ram_empty & in_valid;

  // The single RAM address port is either reading the head or writing the tail.
  assign in_ready    = !fetch & (ram_count < 4'd8);
  assign accept      = in_valid & in_ready;
  assign ram_address = fetch ? rd_ptr : wr_ptr;
  assign ram_write   = accept & !bypass;
  assign ram_in      = in_data;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = ram_count + {3'd0, out_valid_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 3'd0;
    end else if (ram_write) begin
      wr_ptr <= wr_ptr + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 3'd0;
    end else if (fetch) begin
      rd_ptr <= rd_ptr + 3'd1;
    end
  end

  // Write and fetch are mutually exclusive, so at most one adjustment per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_count <= 4'd0;
    end else if (ram_write) begin
      ram_count <= ram_count + 4'd1;
    end else if (fetch) begin
      ram_count <= ram_count - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
    end else if (fetch) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ram_out;
    end else if (bypass) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
